// File: rtl/rv32i_exec_mem_unit.sv
// RV32I execute/memory slice: main decoder, ALU and a word-addressed data memory.
// An external preload port owns the memory write side until init_done rises.
module rv32i_exec_mem_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_dat,
    input  logic                  init_enb,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic [1:0]            wrt_back_src,
    output logic [3:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_results,
    output logic                  alu_zero,
    output logic [DATA_WIDTH-1:0] mem_read_data
);
    localparam int IDX_W   = ADDR_WIDTH - 2;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Shared func3 map for register and immediate ALU forms; only R-type may pick SUB.
    function automatic logic [3:0] alu_op_from_func3(input logic [2:0] f3, input logic alt,
                                                     input logic allow_sub);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic alu_src;
    logic reg_write_dec;
    logic mem_write_dec;
    logic mem_read_dec;
    logic is_branch;
    logic is_jump;

    always_comb begin
        alu_src       = 1'b0;
        imm_src       = IMM_I;
        reg_write_dec = 1'b0;
        mem_write_dec = 1'b0;
        mem_read_dec  = 1'b0;
        wrt_back_src  = WB_ALU;
        alu_ctrl      = ALU_ADD;
        is_branch     = 1'b0;
        is_jump       = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write_dec = 1'b1;
                alu_ctrl      = alu_op_from_func3(func3, func7[5], 1'b1);
            end
            OP_I: begin
                alu_src       = 1'b1;
                reg_write_dec = 1'b1;
                alu_ctrl      = alu_op_from_func3(func3, func7[5], 1'b0);
            end
            OP_LOAD: begin
                alu_src       = 1'b1;
                reg_write_dec = 1'b1;
                mem_read_dec  = 1'b1;
                wrt_back_src  = WB_MEM;
            end
            OP_STORE: begin
                alu_src       = 1'b1;
                imm_src       = IMM_S;
                mem_write_dec = 1'b1;
            end
            OP_BRANCH: begin
                imm_src   = IMM_B;
                alu_ctrl  = ALU_SUB;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                imm_src       = IMM_J;
                reg_write_dec = 1'b1;
                wrt_back_src  = WB_PC4;
                is_jump       = 1'b1;
            end
            default: ;
        endcase
    end

    logic mem_write;
    logic mem_read;

    assign reg_write = rst & reg_write_dec;
    assign mem_write = rst & mem_write_dec;
    assign mem_read  = rst & mem_read_dec;

    logic [DATA_WIDTH-1:0] b_operand;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] alu_y;

    assign b_operand = alu_src ? immediate : rs2;
    assign shamt     = b_operand[SHAMT_W-1:0];

    always_comb begin
        alu_y = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_y = rs1 + b_operand;
            ALU_SUB:  alu_y = rs1 - b_operand;
            ALU_AND:  alu_y = rs1 & b_operand;
            ALU_OR:   alu_y = rs1 | b_operand;
            ALU_XOR:  alu_y = rs1 ^ b_operand;
            ALU_SLL:  alu_y = rs1 << shamt;
            ALU_SRL:  alu_y = rs1 >> shamt;
            ALU_SRA:  alu_y = $unsigned($signed(rs1) >>> shamt);
            ALU_SLT:  alu_y = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1) < $signed(b_operand)};
            ALU_SLTU: alu_y = {{(DATA_WIDTH-1){1'b0}}, rs1 < b_operand};
            default:  alu_y = '0;
        endcase
    end

    assign alu_results = alu_y;
    assign alu_zero    = (alu_y == '0);

    logic branch_taken;

    always_comb begin
        branch_taken = 1'b0;
        if (is_jump) begin
            branch_taken = 1'b1;
        end else if (is_branch) begin
            case (func3)
                3'b000:  branch_taken = alu_zero;
                3'b001:  branch_taken = ~alu_zero;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    assign branch = rst & branch_taken;

    // Word-addressed storage; byte-offset bits and anything above ADDR_WIDTH are dropped.
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    assign wr_en   = rst & (init_done ? mem_write : init_enb);
    assign wr_idx  = init_done ? alu_results[ADDR_WIDTH-1:2] : init_addr[ADDR_WIDTH-1:2];
    assign wr_data = init_done ? rs2 : init_dat;

    // Contents deliberately survive reset; a low rst at the edge only cancels the write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    assign mem_read_data = mem_read ? mem_reg[alu_results[ADDR_WIDTH-1:2]] : '0;
    assign debug_data    = mem_reg[debug_addr[ADDR_WIDTH-1:2]];

    logic unused_bits;
    assign unused_bits = ^{init_addr[1:0], debug_addr[1:0], func7[6], func7[4:0]};

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// Directed and randomized checks of rv32i_exec_mem_unit against an instruction-level
// reference model holding a shadow copy of data memory.
module tb_rv32i_exec_mem_unit;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] immediate = '0;
    logic        init_done = 1'b0;
    logic [9:0]  init_addr = '0;
    logic [31:0] init_dat = '0;
    logic        init_enb = 1'b0;
    logic [9:0]  debug_addr = '0;
    logic [31:0] debug_data;
    logic        branch;
    logic [2:0]  imm_src;
    logic        reg_write;
    logic [1:0]  wrt_back_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_results;
    logic        alu_zero;
    logic [31:0] mem_read_data;

    rv32i_exec_mem_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .immediate(immediate), .init_done(init_done),
        .init_addr(init_addr), .init_dat(init_dat), .init_enb(init_enb),
        .debug_addr(debug_addr), .debug_data(debug_data), .branch(branch),
        .imm_src(imm_src), .reg_write(reg_write), .wrt_back_src(wrt_back_src),
        .alu_ctrl(alu_ctrl), .alu_results(alu_results), .alu_zero(alu_zero),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Instructions are applied just after the falling edge; any write lands on the next rise.
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(negedge clk);
        opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; immediate = imm;
        #1;
    endtask

    task automatic peek(input logic [9:0] addr, input logic [31:0] exp, input string tag);
        debug_addr = addr;
        #1;
        check(tag, debug_data, exp);
    endtask

    // Instruction semantics by mnemonic, as an ISA reference would state them.
    function automatic logic [31:0] alu_semantics(input logic [2:0] f3, input logic alt,
                                                  input logic is_reg, input logic [31:0] a,
                                                  input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (f3)
            3'd0: return (is_reg && alt) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] imm);
        if (op == OP_R) return alu_semantics(f3, f7[5], 1'b1, a, b);
        if (op == OP_I) return alu_semantics(f3, f7[5], 1'b0, a, imm);
        if (op == OP_LOAD || op == OP_STORE) return a + imm;
        if (op == OP_BRANCH) return a - b;
        return a + b;
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic [3:0] by_f3 [8];
        by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (op == OP_BRANCH) return 4'd1;
        if (op != OP_R && op != OP_I) return 4'd0;
        if (f3 == 3'd0 && op == OP_R && f7[5]) return 4'd1;
        if (f3 == 3'd5 && f7[5]) return 4'd7;
        return by_f3[f3];
    endfunction

    initial begin
        logic [6:0]  op_pool [7];
        logic [6:0]  other_pool [5];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] res;
        logic        exp_branch;
        logic [9:0]  pa;

        op_pool    = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, 7'h00};
        other_pool = '{7'h37, 7'h17, 7'h67, 7'h73, 7'h00};

        // Reset held: control enables forced low.
        drive(OP_LOAD, 3'b010, 7'h00, 32'h0, 32'h0, 32'hC);
        check("rst_lw_reg_write", 32'(reg_write), 32'd0);
        check("rst_lw_mem_read_data", mem_read_data, 32'd0);
        drive(OP_JAL, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        check("rst_jal_branch", 32'(branch), 32'd0);

        // Preload every word through the init port, with random byte-offset bits.
        @(negedge clk);
        rst = 1'b1;
        opcode = 7'h00;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            init_addr = 10'(i * 4 + int'($urandom_range(0, 3)));
            init_dat  = (i < 4) ? (32'd1 << i) : $urandom;
            init_enb  = 1'b1;
            model_mem[i] = init_dat;
        end
        @(negedge clk);
        init_enb = 1'b0;
        peek(10'h00C, 32'h0000_0008, "preload_word3");
        peek(10'h000, 32'h0000_0001, "preload_word0");

        // Control stores must be ignored while the preload port owns the memory.
        drive(OP_STORE, 3'b010, 7'h00, 32'h0, 32'hCAFE_F00D, 32'h10);
        drive(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        peek(10'h010, model_mem[4], "store_blocked_before_init_done");

        init_done = 1'b1;
        drive(OP_LOAD, 3'b010, 7'h00, 32'h0, 32'h0, 32'hC);
        check("lw_alu_results", alu_results, 32'h0000_000C);
        check("lw_mem_read_data", mem_read_data, 32'h0000_0008);
        check("lw_reg_write", 32'(reg_write), 32'd1);
        check("lw_wrt_back_src", 32'(wrt_back_src), 32'd0);
        check("lw_imm_src", 32'(imm_src), 32'd0);

        drive(OP_STORE, 3'b010, 7'h00, 32'h4, 32'h8, 32'h8);
        check("sw_reg_write", 32'(reg_write), 32'd0);
        check("sw_imm_src", 32'(imm_src), 32'd1);
        drive(OP_STORE, 3'b010, 7'h00, 32'h4, 32'hDEAD_BEEF, 32'hC);
        peek(10'h010, model_mem[4], "sw_same_cycle_old_word");
        drive(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        model_mem[4] = 32'hDEAD_BEEF;
        peek(10'h00C, 32'h0000_0008, "sw_word3");
        peek(10'h010, 32'hDEAD_BEEF, "sw_word4_new");

        drive(OP_R, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'h0);
        check("sub_result", alu_results, 32'hFFFF_FFFE);
        check("sub_zero", 32'(alu_zero), 32'd0);
        drive(OP_R, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'h0);
        check("sra_result", alu_results, 32'hF800_0000);
        drive(OP_R, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("slt_result", alu_results, 32'd1);
        drive(OP_R, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("sltu_result", alu_results, 32'd0);

        drive(OP_BRANCH, 3'b000, 7'h00, 32'd3, 32'd3, 32'h0);
        check("beq_zero", 32'(alu_zero), 32'd1);
        check("beq_branch", 32'(branch), 32'd1);
        drive(OP_BRANCH, 3'b001, 7'h00, 32'd3, 32'd3, 32'h0);
        check("bne_branch", 32'(branch), 32'd0);
        drive(OP_JAL, 3'b000, 7'h00, 32'h0, 32'h0, 32'h100);
        check("jal_branch", 32'(branch), 32'd1);
        check("jal_wrt_back_src", 32'(wrt_back_src), 32'd2);
        check("jal_imm_src", 32'(imm_src), 32'd3);

        // Random instructions against the reference model, with a busy but ignored preload port.
        for (int n = 0; n < 400; n++) begin
            op  = op_pool[$urandom_range(0, 6)];
            if (op == 7'h00) op = other_pool[$urandom_range(0, 4)];
            f3  = 3'($urandom);
            f7  = $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom);
            a   = $urandom;
            b   = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 8));
            if (op == OP_BRANCH && $urandom_range(0, 1) == 1) b = a;
            if (op == OP_BRANCH) f3 = 3'($urandom_range(0, 2));
            init_enb  = 1'($urandom);
            init_addr = 10'($urandom);
            init_dat  = $urandom;
            drive(op, f3, f7, a, b, imm);

            res = ref_result(op, f3, f7, a, b, imm);
            exp_branch = (op == OP_JAL) ||
                         (op == OP_BRANCH && f3 == 3'd0 && res == 32'd0) ||
                         (op == OP_BRANCH && f3 == 3'd1 && res != 32'd0);
            check("rnd_alu_results", alu_results, res);
            check("rnd_alu_zero", 32'(alu_zero), 32'(res == 32'd0));
            check("rnd_alu_ctrl", 32'(alu_ctrl), 32'(ref_ctrl(op, f3, f7)));
            check("rnd_branch", 32'(branch), 32'(exp_branch));
            check("rnd_reg_write", 32'(reg_write),
                  32'(op == OP_R || op == OP_I || op == OP_LOAD || op == OP_JAL));
            check("rnd_mem_read_data", mem_read_data,
                  (op == OP_LOAD) ? model_mem[res[9:2]] : 32'd0);
            if (op == OP_I || op == OP_LOAD) check("rnd_imm_src_i", 32'(imm_src), 32'd0);
            if (op == OP_STORE)  check("rnd_imm_src_s", 32'(imm_src), 32'd1);
            if (op == OP_BRANCH) check("rnd_imm_src_b", 32'(imm_src), 32'd2);
            if (op == OP_JAL)    check("rnd_imm_src_j", 32'(imm_src), 32'd3);
            if (op == OP_LOAD)   check("rnd_wb_mem", 32'(wrt_back_src), 32'd0);
            if (op == OP_R || op == OP_I || !(op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL}))
                check("rnd_wb_alu", 32'(wrt_back_src), 32'd1);
            if (op == OP_JAL)    check("rnd_wb_pc4", 32'(wrt_back_src), 32'd2);
            pa = 10'($urandom);
            peek(pa, model_mem[pa[9:2]], "rnd_debug_data");
            if (op == OP_STORE) model_mem[res[9:2]] = b;
            $display("txn %0d op=%07b f3=%0d a=%08h b=%08h imm=%08h res=%08h br=%0b",
                     n, op, f3, a, b, imm, res, exp_branch);
        end
        init_enb = 1'b0;

        drive(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        for (int w = 0; w < 256; w++) begin
            peek(10'(w * 4), model_mem[w], "sweep_word");
        end

        // Reset mid-operation: writes on either path are cancelled, enables drop.
        @(negedge clk);
        rst = 1'b0;
        opcode = OP_STORE; func3 = 3'b010; rs1 = 32'h0; rs2 = 32'h1234_5678; immediate = 32'h0;
        #1;
        check("rst_sw_reg_write", 32'(reg_write), 32'd0);
        check("rst_sw_branch", 32'(branch), 32'd0);
        @(negedge clk);
        peek(10'h000, model_mem[0], "rst_sw_mem_unchanged");
        drive(OP_LOAD, 3'b010, 7'h00, 32'h0, 32'h0, 32'hC);
        check("rst_lw_mem_read_data_late", mem_read_data, 32'd0);
        check("rst_lw_reg_write_late", 32'(reg_write), 32'd0);
        peek(10'h00C, model_mem[3], "rst_debug_still_live");
        drive(OP_JAL, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        check("rst_jal_branch_late", 32'(branch), 32'd0);
        init_done = 1'b0;
        init_addr = 10'h000;
        init_dat  = 32'hAAAA_5555;
        init_enb  = 1'b1;
        drive(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        drive(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
        peek(10'h000, model_mem[0], "rst_preload_blocked");
        init_enb  = 1'b0;
        init_done = 1'b1;

        @(negedge clk);
        rst = 1'b1;
        drive(OP_LOAD, 3'b010, 7'h00, 32'h8, 32'h0, 32'h4);
        check("post_rst_lw", mem_read_data, model_mem[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
